fadd_hp_arbiter: RTL
====================

# fadd_hp_arbiter

Two-requester scheduler that shares one combinational half-precision floating-point adder/subtractor (`FAdder_HalfPrecision`) between independent clients. Each requester uses a valid/ready handshake. The block arbitrates between them, registers the operands, and holds them stable for a configurable number of cycles so the adder can run as a multicycle path. It then captures the sum and returns it on a single tagged response channel with backpressure.

## Interface
Parameters:
- HOLD_CYCLES, 1: cycles the operand registers drive the adder before the result is captured; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_add  in  1  1 = a+b, 0 = a−b
- req0_a, req0_b  in  16  operands, packed {sign, exponent[5], mantissa[10]}
- req1_valid, req1_ready, req1_add, req1_a, req1_b: same as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  index of the requester that owns the result
- rsp_result  out  16  packed half-precision result
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states and transitions:
  - IDLE: arbitrate; on any accept, go to EXEC.
  - EXEC: count down; when the count is 0, capture the adder output into rsp_result and go to RESP.
  - RESP: hold the response; when rsp_valid && rsp_ready, go to IDLE.
- Grant logic:
  - reqN_ready = (state == IDLE) && (N is the winner).
  - The winner is computed from both valids, so a ready can depend on the other requester's valid.
  - At most one ready is high per cycle.
- Accept = reqN_valid && reqN_ready. On accept, register the winner's a, b, add and id, and load the counter with HOLD_CYCLES−1.
- Requesters may change their inputs freely after accept. The adder sees only the registered operands.
- The adder's sign, exponent and mantissa fields are wired directly from and to the packed 16-bit values. The arbiter does no arithmetic of its own.
- Response fields (rsp_id, rsp_result) stay stable while rsp_valid && !rsp_ready.
- No new request is accepted in EXEC or RESP.
- Reset forces:
  - state IDLE, counter 0, priority pointer favouring requester 0;
  - all outputs 0 (req*_ready, rsp_valid, rsp_id, rsp_result, busy).
- Reset asserted mid-operation aborts the operation. The in-flight result is discarded and never presented.

## Timing
- Cycle 0: accept. Cycles 1..HOLD_CYCLES: EXEC. Cycle HOLD_CYCLES+1: rsp_valid first high.
- If rsp_ready is high in the first RESP cycle, IDLE is reached the next cycle and a new accept can happen there.
- Peak throughput: one operation per HOLD_CYCLES+2 cycles.
- Latency from accept to rsp_valid: HOLD_CYCLES+1 cycles.
- Reset takes effect asynchronously on assertion. The first accept can occur in the first clock after deassertion.

## Configuration
- FADD_ARB_ROUND_ROBIN_EN defined (round-robin arbitration):
  - The priority pointer records the last granted requester.
  - When both are valid, the other requester wins.
  - The pointer updates only on accept.
- Undefined (fixed priority):
  - Requester 0 always wins when valid.
  - Requester 1 is granted only when req0_valid is low.
  - No pointer flop exists.

## Structure
- Shared package/header fadd_pkg holds:
  - field widths: FP16_W=16, EXP_W=5, MAN_W=10;
  - state encodings: IDLE, EXEC, RESP;
  - FP16 constants used by benches: ONE=0x3C00, TWO=0x4000, THREE=0x4200.
- One natural sub-module, fadd_arb_pick: combinational two-way winner selection from the valids and the pointer, containing the round-robin/fixed-priority switch.
- The shared adder is instantiated directly in fadd_hp_arbiter.

## Test plan
- Single add, HOLD_CYCLES=1: req0 add 0x3C00 + 0x4000 with rsp_ready=1.
  - req0_ready high in cycle 0; rsp_valid high only in cycle 2.
  - rsp_id=0, rsp_result=0x4200; busy high in cycles 1–2.
- Subtract: req1 0x4200 − 0x3C00 (req1_add=0) → rsp_id=1, rsp_result=0x4000.
- Contention: both valid continuously for 4 operations, rsp_ready=1.
  - With FADD_ARB_ROUND_ROBIN_EN: grant order 0,1,0,1.
  - Without it: 0,0,0,0, and req1_ready is never high.
- Backpressure: rsp_ready held low for 5 cycles after rsp_valid rises.
  - rsp_valid, rsp_id and rsp_result stay constant; both readys stay 0.
  - Completion occurs in the cycle rsp_ready rises.
- HOLD_CYCLES=4: accept in cycle 0 → rsp_valid first high in cycle 5, with the correct sum.
- Reset asserted during EXEC: all outputs go to 0 immediately with no response emitted.
  - After release, an op on req0 completes normally.
  - Under round-robin, the first contended grant after reset goes to requester 0.

Source files
------------

// File: rtl/fadd_pkg.sv
// Shared widths, FSM encoding and FP16 constants for the fadd_hp_arbiter block
// and its half-precision adder.
package fadd_pkg;

  localparam int FP16_W = 16;
  localparam int EXP_W  = 5;
  localparam int MAN_W  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  localparam logic [FP16_W-1:0] ONE   = 16'h3C00;
  localparam logic [FP16_W-1:0] TWO   = 16'h4000;
  localparam logic [FP16_W-1:0] THREE = 16'h4200;

endpackage

// File: rtl/FAdder_HalfPrecision.sv
// Combinational IEEE-754 binary16 adder/subtractor with round-to-nearest-even,
// subnormal support and Inf/NaN propagation.
module FAdder_HalfPrecision
  import fadd_pkg::*;
(
  input  logic             a_sign,
  input  logic [EXP_W-1:0] a_exp,
  input  logic [MAN_W-1:0] a_man,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  input  logic             add,
  output logic             r_sign,
  output logic [EXP_W-1:0] r_exp,
  output logic [MAN_W-1:0] r_man
);

  localparam int SIG_W = MAN_W + 1;
  localparam int EXT_W = SIG_W + 3;

  logic               b_sign_eff, swap, sub;
  logic               x_sign, y_sign;
  logic [EXP_W-1:0]   x_exp, y_exp, x_e, y_e, diff;
  logic [MAN_W-1:0]   x_man, y_man;
  logic [SIG_W-1:0]   x_sig, y_sig;
  logic [EXT_W-1:0]   x_al, y_al, norm;
  logic [2*EXT_W-1:0] y_wide;
  logic [EXT_W:0]     sum;
  logic [6:0]         e;
  logic               round_up;
  logic [SIG_W:0]     rnd;

  always_comb begin
    b_sign_eff = b_sign ^ ~add;
    // Order operands by magnitude so the difference is never negative.
    swap   = {b_exp, b_man} > {a_exp, a_man};
    x_sign = swap ? b_sign_eff : a_sign;
    y_sign = swap ? a_sign : b_sign_eff;
    x_exp  = swap ? b_exp : a_exp;
    y_exp  = swap ? a_exp : b_exp;
    x_man  = swap ? b_man : a_man;
    y_man  = swap ? a_man : b_man;
    sub    = x_sign ^ y_sign;

    x_sig = {x_exp != '0, x_man};
    y_sig = {y_exp != '0, y_man};
    x_e   = (x_exp == '0) ? EXP_W'(1) : x_exp;
    y_e   = (y_exp == '0) ? EXP_W'(1) : y_exp;
    diff  = x_e - y_e;

    x_al   = {x_sig, 3'b000};
    y_wide = {y_sig, 3'b000, {EXT_W{1'b0}}} >> diff;
    if (diff > 5'd24) y_al = {{(EXT_W-1){1'b0}}, |y_sig};
    else              y_al = y_wide[2*EXT_W-1:EXT_W] | {{(EXT_W-1){1'b0}}, |y_wide[EXT_W-1:0]};

    sum = sub ? ({1'b0, x_al} - {1'b0, y_al}) : ({1'b0, x_al} + {1'b0, y_al});
    e   = {2'b00, x_e};

    if (sum[EXT_W]) begin
      norm = sum[EXT_W:1] | {{(EXT_W-1){1'b0}}, sum[0]};
      e    = e + 7'd1;
    end else begin
      norm = sum[EXT_W-1:0];
      for (int i = 0; i < EXT_W; i++) begin
        if (!norm[EXT_W-1] && e > 7'd1) begin
          norm = norm << 1;
          e    = e - 7'd1;
        end
      end
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, round_up};
    if (rnd[SIG_W]) begin
      rnd = rnd >> 1;
      e   = e + 7'd1;
    end

    r_sign = x_sign;
    r_exp  = '0;
    r_man  = '0;
    if (&x_exp) begin
      // x carries the largest pattern, so any NaN operand lands here.
      if (|x_man || (&y_exp && sub)) begin
        r_sign = 1'b0;
        r_exp  = '1;
        r_man  = {1'b1, {(MAN_W-1){1'b0}}};
      end else begin
        r_exp = '1;
      end
    end else if (sum == '0) begin
      r_sign = x_sign & y_sign;
    end else if (e >= 7'd31) begin
      r_exp = '1;
    end else begin
      // A subnormal that rounds up into the hidden bit becomes the smallest normal.
      r_exp = rnd[MAN_W] ? e[EXP_W-1:0] : '0;
      r_man = rnd[MAN_W-1:0];
    end
  end

endmodule

// File: rtl/fadd_arb_pick.sv
// Two-way winner selection. FADD_ARB_ROUND_ROBIN_EN selects round-robin against
// the last granted requester; otherwise requester 0 has fixed priority.
module fadd_arb_pick (
  input  logic valid0,
  input  logic valid1,
`ifdef FADD_ARB_ROUND_ROBIN_EN
  input  logic last,
`endif
  output logic grant0,
  output logic grant1
);

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef FADD_ARB_ROUND_ROBIN_EN
    if (valid0 && valid1) begin
      grant0 = last;
      grant1 = !last;
    end else begin
      grant0 = valid0;
      grant1 = valid1;
    end
`else
    grant0 = valid0;
    grant1 = valid1 && !valid0;
`endif
  end

endmodule

// File: rtl/fadd_hp_arbiter.sv
// Two-requester scheduler around one multicycle FP16 adder. Define
// FADD_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module fadd_hp_arbiter
  import fadd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_add,
  input  logic [FP16_W-1:0] req0_a,
  input  logic [FP16_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_add,
  input  logic [FP16_W-1:0] req1_a,
  input  logic [FP16_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [FP16_W-1:0] rsp_result,
  output logic              busy
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t     state;
  logic [3:0] count;
  fp16_t      op_a, op_b, sum;
  logic       op_add, op_id;
  logic       grant0, grant1, accept0, accept1;

`ifdef FADD_ARB_ROUND_ROBIN_EN
  logic last;
`endif

  fadd_arb_pick u_pick (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
`ifdef FADD_ARB_ROUND_ROBIN_EN
    .last   (last),
`endif
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Readys are gated by reset so every output reads 0 while reset is held.
  assign req0_ready = (state == IDLE) && grant0 && !reset;
  assign req1_ready = (state == IDLE) && grant1 && !reset;
  assign accept0    = req0_valid && req0_ready;
  assign accept1    = req1_valid && req1_ready;

  FAdder_HalfPrecision u_fadd (
    .a_sign (op_a.sign),
    .a_exp  (op_a.exp),
    .a_man  (op_a.man),
    .b_sign (op_b.sign),
    .b_exp  (op_b.exp),
    .b_man  (op_b.man),
    .add    (op_add),
    .r_sign (sum.sign),
    .r_exp  (sum.exp),
    .r_man  (sum.man)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_add     <= 1'b0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      busy       <= 1'b0;
`ifdef FADD_ARB_ROUND_ROBIN_EN
      last       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept0 || accept1) begin
            op_a   <= accept0 ? req0_a : req1_a;
            op_b   <= accept0 ? req0_b : req1_b;
            op_add <= accept0 ? req0_add : req1_add;
            op_id  <= accept1;
            count  <= HOLD_LOAD;
            state  <= EXEC;
            busy   <= 1'b1;
`ifdef FADD_ARB_ROUND_ROBIN_EN
            last   <= accept1;
`endif
          end
        end
        EXEC: begin
          if (count == '0) begin
            rsp_result <= sum;
            rsp_id     <= op_id;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
